instr_fetch: RTL and testbench
==============================

# instr_fetch

Program sequencer and instruction store that sits directly upstream of the cute processor. It holds a loadable program and presents 9-bit instruction words on `DIN` with a one-cycle `Run` pulse. It then waits for the processor's `done`, supplying an immediate word on request. On `done` it advances or jumps the program counter and stops when it fetches a HALT word.

## Interface

- `ADDR_W`, default 6: program-counter and address width.
- `DEPTH` = 2**`ADDR_W` (64): number of program words.
- `HALT_OP`, default 3'b100: opcode in `DIN[8:6]` that stops the sequencer.
- `clk`  in  1: clock, rising edge.
- `Resetn`  in  1: synchronous, active-low reset.
- `start`  in  1: leave IDLE or HALTED and begin execution at the current or restart PC.
- `ld_en`  in  1: program-load write strobe.
- `ld_addr`  in  ADDR_W: program-load address.
- `ld_data`  in  9: program-load data.
- `done`  in  1: processor finished the current instruction.
- `imm_req`  in  1: processor wants the next word as an immediate.
- `jmp`  in  1: processor requests a branch; qualified by `done`.
- `jmp_target`  in  ADDR_W: branch destination (processor `bus[5:0]`).
- `DIN`  out  9: instruction or immediate word presented to the processor; registered.
- `Run`  out  1: one-cycle issue pulse; registered.
- `pc`  out  ADDR_W: current program counter.
- `halted`  out  1: HALT word reached.

## Operation

- Program memory is `DEPTH` x 9 bits.
  - It is written only through the load port, and only in IDLE or HALTED.
  - `ld_en` is ignored in any other state.
  - Contents are not cleared by reset.
- Reset (`Resetn`=0 at an edge) sets:
  - state IDLE
  - `pc`=0, `DIN`=0, `Run`=0, `halted`=0.
- **IDLE**
  - `start`=1 → FETCH.
- **FETCH**
  - `DIN` ← mem[`pc`].
  - If mem[`pc`][8:6]==`HALT_OP`: go to HALTED and set `halted`=1. No `Run` is issued.
  - Otherwise go to ISSUE with `Run` ← 1.
- **ISSUE** (exactly one cycle, `Run`=1)
  - `Run` ← 0, then go to WAIT.
  - `done` and `imm_req` are sampled here exactly as in WAIT.
- **WAIT** (`Run`=0, `DIN` held)
  - `imm_req`=1 and `done`=0:
    - `pc` ← `pc`+1 and `DIN` ← mem[`pc`+1], both in the same edge.
    - Stay in WAIT.
  - `done`=1:
    - If `jmp`=1, `pc` ← `jmp_target`; otherwise `pc` ← `pc`+1.
    - Go to FETCH.
  - `done` and `imm_req` both high: `done` wins and `imm_req` is ignored.
  - `jmp` without `done` is ignored.
- **HALTED**
  - `halted`=1 and `pc` is frozen at the HALT address.
  - `start`=1 → `pc` ← 0, `halted` ← 0, go to FETCH.
- PC arithmetic is modulo `DEPTH`. PC `DEPTH`-1 increments to 0, and an immediate fetch at `DEPTH`-1 reads word 0.
- `start` is ignored in FETCH, ISSUE and WAIT.

## Timing

- `start` sampled in IDLE at edge k:
  - FETCH during cycle k+1.
  - `Run`=1 with valid `DIN` during cycle k+2.
- Issue latency from `done` sampled at edge n:
  - Next `DIN` is valid and `Run`=1 during cycle n+2, i.e. one dead cycle in FETCH.
- `DIN` is stable from the `Run` cycle until the next FETCH or immediate update.
  - The processor may sample it in any cycle of ISSUE or WAIT.
- Immediate fetch latency: the new `DIN` is valid in the cycle after the `imm_req` edge.
- Reset mid-operation: reset takes priority over all inputs at that edge.
  - An in-flight `done` or `imm_req` is discarded.
  - `Run` falls immediately at that edge.
- Load and `start` in the same IDLE cycle: the write completes, and FETCH reads the updated word.

## Test plan

- **Straight-line run**
  - Stimulus: load 001000001, 000010011, 011000011, 100000000 at 0..3; `start`; answer `done` 3 cycles after each `Run`.
  - Required: three `Run` pulses with `DIN` = 0x041, 0x013, 0x0C3; `pc` 0→1→2→3; `halted`=1 at `pc`=3 with no fourth `Run`.
- **Immediate**
  - Stimulus: word 0 = 001000001, word 1 = 0x0AA, word 2 = HALT; pulse `imm_req` 1 cycle after `Run`, then `done`.
  - Required: `DIN`=0x0AA the next cycle; `pc`=1 then 2; `halted`=1.
- **Jump**
  - Stimulus: `done` with `jmp`=1 and `jmp_target`=5.
  - Required: next `Run` carries mem[5]; `pc`=5. A `jmp`=1 pulse without `done` leaves `pc` unchanged.
- **Wrap-around**
  - Stimulus: `jmp_target`=63, then `done` at word 63.
  - Required: `pc` 63→0 and the next fetch reads word 0.
- **Simultaneous `done` and `imm_req`**
  - Required: `pc` increments exactly once and goes to FETCH; `DIN` is not updated by `imm_req`.
- **Reset mid-WAIT and load lockout**
  - Stimulus: drive `Resetn`=0 in WAIT, with `ld_en` asserted during WAIT beforehand.
  - Required: `Run`=0, `pc`=0, `DIN`=0, state IDLE. The memory word written during WAIT is unchanged; a write made in IDLE takes effect.

Source files
------------

// File: rtl/instr_fetch.sv
// Program sequencer and instruction store feeding the cute processor: holds a
// loadable program, issues words on DIN with a Run pulse, and follows done/jmp.
module instr_fetch #(
  parameter int          ADDR_W  = 6,
  parameter logic [2:0]  HALT_OP = 3'b100
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              start,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [8:0]        ld_data,
  input  logic              done,
  input  logic              imm_req,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t            state;
  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] pc_inc;
  logic [8:0]        cur_word;
  logic [8:0]        next_word;
  logic              load_ok;

  // Increment wraps naturally at DEPTH-1 because pc_inc is ADDR_W bits wide.
  assign pc_inc    = pc + ADDR_W'(1);
  assign cur_word  = mem[pc];
  assign next_word = mem[pc_inc];
  assign load_ok   = ld_en && ((state == S_IDLE) || (state == S_HALTED));

  // NOTE: the program store has no reset so it maps onto plain RAM and a
  // program survives Resetn; only the sequencer state below is reset.
  always_ff @(posedge clk) begin
    if (load_ok) mem[ld_addr] <= ld_data;
  end

  // NOTE: every register here uses non-blocking assignment so all branches
  // see the pre-edge values of pc, state and the memory words.
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state  <= S_IDLE;
      pc     <= '0;
      DIN    <= '0;
      Run    <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          DIN <= cur_word;
          if (cur_word[8:6] == HALT_OP) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            Run   <= 1'b1;
            state <= S_ISSUE;
          end
        end
        // The issue cycle reacts to done/imm_req exactly like a wait cycle.
        S_ISSUE, S_WAIT: begin
          Run <= 1'b0;
          if (done) begin
            pc    <= jmp ? jmp_target : pc_inc;
            state <= S_FETCH;
          end else if (imm_req) begin
            pc    <= pc_inc;
            DIN   <= next_word;
            state <= S_WAIT;
          end else begin
            state <= S_WAIT;
          end
        end
        S_HALTED: begin
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a transaction-level model of the processor handshake
// checks every cycle, and directed scenarios pin hand-computed values.
module tb_instr_fetch;

  localparam int         AW   = 6;
  localparam logic [2:0] HALT = 3'b100;

  logic          clk = 1'b0;
  logic          Resetn = 1'b0;
  logic          start = 1'b0, ld_en = 1'b0, done = 1'b0, imm_req = 1'b0, jmp = 1'b0;
  logic [AW-1:0] ld_addr = '0, jmp_target = '0, pc;
  logic [8:0]    ld_data = '0, DIN;
  logic          Run, halted;

  int checks = 0, failures = 0, run_cnt = 0;
  logic [8:0] mem_model [64];

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(AW), .HALT_OP(HALT)) dut (
    .clk(clk), .Resetn(Resetn), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .done(done), .imm_req(imm_req), .jmp(jmp),
    .jmp_target(jmp_target), .DIN(DIN), .Run(Run), .pc(pc), .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: once a word is issued the processor is "busy"; the consequence of
  // each sampled done/imm_req is checked one and two cycles later.
  bit            p_valid = 0, busy = 0;
  logic          p_rstn, p_busy, p_imm;
  logic [AW-1:0] p_pc, exp_pc, nxt;
  logic [8:0]    p_din;
  int            fcnt = 0;

  always @(negedge clk) begin
    if (p_valid) begin
      if (!p_rstn) begin
        check("reset_run", Run, 0);
        check("reset_pc", pc, 0);
        check("reset_din", DIN, 0);
        check("reset_halted", halted, 0);
        busy = 0;
        fcnt = 0;
      end else if (fcnt == 2) begin
        check("fetch_dead_run", Run, 0);
        check("fetch_pc", pc, exp_pc);
        fcnt = 1;
      end else if (fcnt == 1) begin
        check("issue_pc", pc, exp_pc);
        check("issue_din", DIN, mem_model[exp_pc]);
        if (mem_model[exp_pc][8:6] == HALT) begin
          check("halt_flag", halted, 1);
          check("halt_no_run", Run, 0);
        end else begin
          check("issue_run", Run, 1);
          check("issue_not_halted", halted, 0);
        end
        fcnt = 0;
      end else if (p_busy) begin
        nxt = p_pc + AW'(1);
        check("wait_run_low", Run, 0);
        if (p_imm) begin
          check("imm_pc", pc, nxt);
          check("imm_din", DIN, mem_model[nxt]);
        end else begin
          check("hold_pc", pc, p_pc);
          check("hold_din", DIN, p_din);
        end
      end
    end
    if (Run === 1'b1) begin
      run_cnt++;
      check("run_din_matches_mem", DIN, mem_model[pc]);
      busy = 1;
    end
    if (Resetn && busy && done) begin
      exp_pc = jmp ? jmp_target : pc + AW'(1);
      fcnt   = 2;
      busy   = 0;
    end
    p_valid = 1;
    p_rstn  = Resetn;
    p_busy  = busy;
    p_imm   = imm_req;
    p_pc    = pc;
    p_din   = DIN;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [8:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    mem_model[a] = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run(input string name);
    for (int i = 0; i < 40 && Run !== 1'b1; i++) tick();
    check({name, "_run_seen"}, Run, 1);
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 40 && halted !== 1'b1; i++) tick();
    check({name, "_halted"}, halted, 1);
  endtask

  // Processor answer: done (with optional jump) `delay` cycles after Run.
  task automatic respond(input int delay, input bit j, input logic [AW-1:0] t);
    if (delay > 0) tick(delay);
    done = 1'b1; jmp = j; jmp_target = t;
    tick();
    done = 1'b0; jmp = 1'b0;
  endtask

  logic [8:0] t1_din [3] = '{9'h041, 9'h013, 9'h0C3};
  int base;

  initial begin
    tick(3);
    Resetn = 1'b1;
    check("init_run", Run, 0);
    check("init_pc", pc, 0);
    check("init_din", DIN, 0);
    check("init_halted", halted, 0);

    // Straight-line run
    load(0, 9'b001000001); load(1, 9'b000010011);
    load(2, 9'b011000011); load(3, 9'b100000000);
    base = run_cnt;
    do_start();
    for (int i = 0; i < 3; i++) begin
      wait_run("t1");
      check("t1_din", DIN, t1_din[i]);
      check("t1_pc", pc, i);
      respond(3, 0, 0);
    end
    wait_halt("t1");
    tick(3);
    check("t1_halt_pc", pc, 3);
    check("t1_run_count", run_cnt - base, 3);

    // Immediate
    load(1, 9'h0AA); load(2, 9'h100);
    do_start();
    wait_run("t2");
    check("t2_pc0", pc, 0);
    check("t2_din0", DIN, 9'h041);
    tick();
    imm_req = 1'b1;
    tick();
    imm_req = 1'b0;
    check("t2_imm_din", DIN, 9'h0AA);
    check("t2_imm_pc", pc, 1);
    respond(1, 0, 0);
    check("t2_pc2", pc, 2);
    wait_halt("t2");
    check("t2_halt_pc", pc, 2);

    // Jump
    load(5, 9'h0C5); load(6, 9'h100);
    do_start();
    wait_run("t3");
    tick();
    jmp = 1'b1; jmp_target = 9;
    tick();
    jmp = 1'b0;
    check("t3_jmp_without_done_pc", pc, 0);
    respond(1, 1, 5);
    check("t3_jmp_pc", pc, 5);
    wait_run("t3b");
    check("t3_target_din", DIN, 9'h0C5);
    check("t3_target_pc", pc, 5);
    respond(2, 0, 0);
    wait_halt("t3");
    check("t3_halt_pc", pc, 6);

    // Wrap-around, including an immediate fetch at the last word
    load(63, 9'h07F);
    do_start();
    wait_run("t4");
    respond(1, 1, 63);
    wait_run("t4b");
    check("t4_pc63", pc, 63);
    check("t4_din63", DIN, 9'h07F);
    respond(2, 0, 0);
    check("t4_wrap_pc", pc, 0);
    wait_run("t4c");
    check("t4_wrap_din", DIN, 9'h041);
    respond(1, 1, 63);
    wait_run("t4d");
    tick();
    imm_req = 1'b1;
    tick();
    imm_req = 1'b0;
    check("t4_imm_wrap_pc", pc, 0);
    check("t4_imm_wrap_din", DIN, 9'h041);
    respond(1, 1, 6);
    wait_halt("t4");

    // Simultaneous done and imm_req; then done during the issue cycle
    do_start();
    wait_run("t5");
    tick(2);
    done = 1'b1; imm_req = 1'b1;
    tick();
    done = 1'b0; imm_req = 1'b0;
    check("t5_pc_once", pc, 1);
    check("t5_din_not_imm", DIN, 9'h041);
    check("t5_run_low", Run, 0);
    wait_run("t5b");
    check("t5_next_din", DIN, 9'h0AA);
    respond(0, 1, 6);
    check("t5_issue_done_pc", pc, 6);
    wait_halt("t5");

    // Reset mid-WAIT with load lockout
    do_start();
    wait_run("t6");
    tick();
    ld_en = 1'b1; ld_addr = 0; ld_data = 9'h1FF;
    tick();
    ld_en = 1'b0;
    tick();
    Resetn = 1'b0; done = 1'b1;
    tick();
    Resetn = 1'b1; done = 1'b0;
    check("t6_rst_run", Run, 0);
    check("t6_rst_pc", pc, 0);
    check("t6_rst_din", DIN, 0);
    check("t6_rst_halted", halted, 0);
    tick(2);
    check("t6_idle_pc", pc, 0);
    check("t6_idle_run", Run, 0);
    do_start();
    wait_run("t6b");
    check("t6_lockout_din", DIN, 9'h041);
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    ld_en = 1'b1; ld_addr = 0; ld_data = 9'h0D2; start = 1'b1;
    mem_model[0] = 9'h0D2;
    tick();
    ld_en = 1'b0; start = 1'b0;
    wait_run("t6c");
    check("t6_idle_write_din", DIN, 9'h0D2);
    check("t6_idle_write_pc", pc, 0);
    respond(1, 1, 6);
    wait_halt("t6");
    tick(3);
    check("t6_halt_frozen_pc", pc, 6);
    check("t6_halt_no_run", Run, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
